snoop_bus_arbiter: RTL and testbench

SNOOP_BUS_ARBITER -- requirements
Module: snoop_bus_arbiter

---
 rtl/snoop_bus_arbiter_pkg.sv | 34 +++
 rtl/snoop_bus_arbiter_rr.sv | 23 ++
 rtl/snoop_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/snoop_bus_arbiter_pkg.sv
// Shared cache definitions for the snoop bus arbiter: ADDRESSSIZE, core count, op and state encodings.
// The optional ARB_ROUND_ROBIN_EN macro is consumed by snoop_bus_arbiter.sv.
`ifndef ADDRESSSIZE
`define ADDRESSSIZE 16
`endif

package snoop_bus_arbiter_pkg;

    localparam int NUM_CORES = 4;
    localparam int ADDR_W    = `ADDRESSSIZE;

    typedef enum logic [1:0] {
        OP_NONE   = 2'b00,
        OP_BUSRD  = 2'b01,
        OP_BUSRDX = 2'b10,
        OP_INV    = 2'b11
    } bus_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SNOOP = 2'b01,
        ST_RESP  = 2'b10
    } arb_state_t;

    function automatic logic [1:0] onehot_to_idx(input logic [NUM_CORES-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/snoop_bus_arbiter_rr.sv
// rr_arbiter_4: combinational winner pick over four eligible cores, searching upward from ptr.
// A constant ptr of 0 turns it into a fixed-priority (core 0 highest) selector.
module rr_arbiter_4
    import snoop_bus_arbiter_pkg::*;
(
    input  logic [NUM_CORES-1:0] eligible,
    input  logic [1:0]           ptr,
    output logic [NUM_CORES-1:0] winner
);

    logic [1:0] idx;

    // Walk from the farthest candidate to the nearest so the nearest eligible one overwrites.
    always_comb begin
        winner = '0;
        idx    = ptr;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (eligible[idx]) winner = 4'b0001 << idx;
        end
    end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snoop bus arbiter: grants one of four cores, broadcasts its op/address for SNOOP_CYCLES, then pulses Done.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (core 0 highest).
`ifndef ADDRESSSIZE
`define ADDRESSSIZE 16
`endif

module snoop_bus_arbiter
    import snoop_bus_arbiter_pkg::*;
#(
    parameter int SNOOP_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [3:0]                Bus_Req,
    input  logic [7:0]                Bus_Op,
    input  logic [4*`ADDRESSSIZE-1:0] Bus_Addr,
    input  logic [3:0]                Shared_In,
    output logic [3:0]                Grant,
    output logic                      BusRd,
    output logic                      BusRdX,
    output logic                      Invalidate,
    output logic [`ADDRESSSIZE-1:0]   Address_Com,
    output logic                      Shared,
    output logic [3:0]                Done,
    output logic [1:0]                state_dbg
);

    arb_state_t            state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [NUM_CORES-1:0]  grant_q;
    logic [1:0]            op_q;
    logic [ADDR_W-1:0]     addr_q;
    logic                  shared_q;

    logic [NUM_CORES-1:0]  eligible;
    logic [NUM_CORES-1:0]  winner;
    logic [1:0]            ptr_q;
    logic [1:0]            sel_op;
    logic [ADDR_W-1:0]     sel_addr;
    logic                  start;
    logic                  last_snoop;

    always_comb begin
        eligible = '0;
        sel_op   = OP_NONE;
        sel_addr = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            eligible[i] = Bus_Req[i] && (Bus_Op[2*i +: 2] != OP_NONE);
            if (winner[i]) begin
                sel_op   = Bus_Op[2*i +: 2];
                sel_addr = Bus_Addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign start      = (state_q == ST_IDLE) && (|eligible);
    assign last_snoop = (cnt_q == 3'(SNOOP_CYCLES - 1));

    rr_arbiter_4 u_rr (
        .eligible (eligible),
        .ptr      (ptr_q),
        .winner   (winner)
    );

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 2'd0;
        end else if (start) begin
            ptr_q <= onehot_to_idx(winner) + 2'd1;
        end
    end
`else
    assign ptr_q = 2'd0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SNOOP;
                    cnt_d   = 3'd0;
                end
            end
            ST_SNOOP: begin
                if (last_snoop) begin
                    state_d = ST_RESP;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Transaction registers: bus inputs are only looked at in IDLE, so the window ignores later changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q  <= '0;
            op_q     <= OP_NONE;
            addr_q   <= '0;
            shared_q <= 1'b0;
        end else begin
            if (start) begin
                grant_q <= winner;
                op_q    <= sel_op;
                addr_q  <= sel_addr;
            end
            if ((state_q == ST_SNOOP) && last_snoop) begin
                shared_q <= |(Shared_In & ~grant_q);
            end
        end
    end

    always_comb begin
        Grant       = (state_q != ST_IDLE) ? grant_q : '0;
        BusRd       = (state_q == ST_SNOOP) && (op_q == OP_BUSRD);
        BusRdX      = (state_q == ST_SNOOP) && (op_q == OP_BUSRDX);
        Invalidate  = (state_q == ST_SNOOP) && (op_q == OP_INV);
        Address_Com = (state_q == ST_SNOOP) ? addr_q : '0;
        Shared      = (state_q == ST_RESP) && shared_q;
        Done        = (state_q == ST_RESP) ? grant_q : '0;
        state_dbg   = state_q;
    end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Self-checking bench for snoop_bus_arbiter: scoreboard of expected transactions popped on each Done pulse.
// Honors ARB_ROUND_ROBIN_EN to predict the arbitration order.
`ifndef ADDRESSSIZE
`define ADDRESSSIZE 16
`endif

module tb_snoop_bus_arbiter;

    localparam int AW    = `ADDRESSSIZE;
    localparam int SC    = 2;
    localparam int EXP_W = 4 + 2 + AW + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [3:0]        Bus_Req = '0;
    logic [7:0]        Bus_Op = '0;
    logic [4*AW-1:0]   Bus_Addr = '0;
    logic [3:0]        Shared_In = '0;
    logic [3:0]        Grant;
    logic              BusRd, BusRdX, Invalidate;
    logic [AW-1:0]     Address_Com;
    logic              Shared;
    logic [3:0]        Done;
    logic [1:0]        state_dbg;

    snoop_bus_arbiter #(.SNOOP_CYCLES(SC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Bus_Req     (Bus_Req),
        .Bus_Op      (Bus_Op),
        .Bus_Addr    (Bus_Addr),
        .Shared_In   (Shared_In),
        .Grant       (Grant),
        .BusRd       (BusRd),
        .BusRdX      (BusRdX),
        .Invalidate  (Invalidate),
        .Address_Com (Address_Com),
        .Shared      (Shared),
        .Done        (Done),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int model_ptr = 0;
    logic [EXP_W-1:0] exp_q[$];

    int            win_cnt = 0;
    logic          win_bad = 1'b0;
    logic [3:0]    win_grant = '0;
    logic [1:0]    win_op = '0;
    logic [AW-1:0] win_addr = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [1:0] strobe_code(input logic rd, input logic rdx, input logic inv);
        case ({rd, rdx, inv})
            3'b100:  return 2'b01;
            3'b010:  return 2'b10;
            3'b001:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic int model_pick(input logic [3:0] mask);
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 4; k++) begin
            if (mask[(model_ptr + k) % 4]) return (model_ptr + k) % 4;
        end
`else
        for (int k = 0; k < 4; k++) begin
            if (mask[k]) return k;
        end
`endif
        return 0;
    endfunction

    function automatic logic [1:0] op_of(input int core);
        case (core)
            0:       return 2'b01;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic logic [AW-1:0] addr_of(input int core);
        return AW'(32'h100 * (core + 1) + core);
    endfunction

    // driver tasks
    task automatic push_exp(input int core, input logic [1:0] op, input logic [AW-1:0] addr,
                            input logic [3:0] shin);
        logic [3:0] g;
        g = 4'b0001 << core;
        exp_q.push_back({g, op, addr, |(shin & ~g)});
        model_ptr = (core + 1) % 4;
    endtask

    task automatic wait_done(input int n);
        for (int t = 0; t < n; t++) begin
            int cyc;
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (Done == 4'b0 && cyc < 60);
            check_eq("done_seen", 32'(Done != 4'b0), 32'd1);
            if (Done == 4'b0) return;
        end
    endtask

    task automatic do_txn(input int core, input logic [1:0] op, input logic [AW-1:0] addr,
                          input logic [3:0] shin);
        @(posedge clk); #1;
        Bus_Req[core]            = 1'b1;
        Bus_Op[2*core +: 2]      = op;
        Bus_Addr[core*AW +: AW]  = addr;
        Shared_In                = shin;
        push_exp(core, op, addr, shin);
        wait_done(1);
        Bus_Req = '0;
        Bus_Op  = '0;
    endtask

    task automatic contend(input logic [3:0] mask, input int n);
        @(posedge clk); #1;
        Shared_In = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                Bus_Req[i]           = 1'b1;
                Bus_Op[2*i +: 2]     = op_of(i);
                Bus_Addr[i*AW +: AW] = addr_of(i);
            end
        end
        for (int k = 0; k < n; k++) begin
            int c;
            c = model_pick(mask);
            push_exp(c, op_of(c), addr_of(c), 4'b0001);
        end
        wait_done(n);
        Bus_Req = '0;
        Bus_Op  = '0;
    endtask

    // scoreboard: collect the snoop window, compare against the oldest expectation on Done
    always @(negedge clk) begin
        if (!rst_n) begin
            win_cnt = 0;
            win_bad = 1'b0;
        end else begin
            if (BusRd || BusRdX || Invalidate) begin
                if (win_cnt == 0) begin
                    win_grant = Grant;
                    win_op    = strobe_code(BusRd, BusRdX, Invalidate);
                    win_addr  = Address_Com;
                end else if (Grant !== win_grant || Address_Com !== win_addr ||
                             strobe_code(BusRd, BusRdX, Invalidate) !== win_op) begin
                    win_bad = 1'b1;
                end
                if (Shared !== 1'b0 || Done !== 4'b0) win_bad = 1'b1;
                win_cnt++;
            end
            if (Done != 4'b0) begin
                if (exp_q.size() == 0) begin
                    check_eq("done_unexpected", 32'(Done), 32'd0);
                end else begin
                    logic [3:0]    e_g;
                    logic [1:0]    e_op;
                    logic [AW-1:0] e_addr;
                    logic          e_sh;
                    {e_g, e_op, e_addr, e_sh} = exp_q.pop_front();
                    check_eq("done",       32'(Done),      32'(e_g));
                    check_eq("resp_grant", 32'(Grant),     32'(e_g));
                    check_eq("resp_strb",  32'({BusRd, BusRdX, Invalidate}), 32'd0);
                    check_eq("shared",     32'(Shared),    32'(e_sh));
                    check_eq("win_grant",  32'(win_grant), 32'(e_g));
                    check_eq("win_op",     32'(win_op),    32'(e_op));
                    check_eq("win_addr",   32'(win_addr),  32'(e_addr));
                    check_eq("win_len",    32'(win_cnt),   32'(SC));
                    check_eq("win_stable", 32'(win_bad),   32'd0);
                end
                win_cnt = 0;
                win_bad = 1'b0;
            end
        end
    end

    initial begin
        // reset, with a request already pending
        Bus_Req  = 4'b0001;
        Bus_Op   = 8'b0000_0001;
        Bus_Addr = {(3*AW)'(0), AW'(16'h0040)};
        repeat (2) @(negedge clk);
        check_eq("rst_outs", 32'({Grant, BusRd, BusRdX, Invalidate, Address_Com, Shared, Done}), 32'd0);
        check_eq("rst_state", 32'(state_dbg), 32'd0);
        rst_n = 1'b1;
        push_exp(0, 2'b01, AW'(16'h0040), 4'b0000);
        @(posedge clk); #1;
        check_eq("first_grant", 32'(Grant), 32'b0001);
        check_eq("first_busrd", 32'(BusRd), 32'd1);
        check_eq("first_addr", 32'(Address_Com), 32'h40);
        wait_done(1);
        Bus_Req = '0;
        Bus_Op  = '0;
        @(posedge clk); #1;
        check_eq("idle_after", 32'(Grant), 32'd0);

        // shared masking: owner's own hit is excluded
        do_txn(2, 2'b10, AW'(16'h02A0), 4'b0100);
        do_txn(2, 2'b10, AW'(16'h02A4), 4'b0101);

        // op 00 is not a request
        @(posedge clk); #1;
        Bus_Req = 4'b1000;
        Bus_Op  = 8'b0000_0000;
        repeat (4) @(negedge clk);
        check_eq("op00_state", 32'(state_dbg), 32'd0);
        check_eq("op00_grant", 32'(Grant), 32'd0);
        check_eq("op00_strb", 32'({BusRd, BusRdX, Invalidate}), 32'd0);
        Bus_Req = '0;

        // reset during the first snoop cycle of an Invalidate
        @(posedge clk); #1;
        Bus_Req[3]          = 1'b1;
        Bus_Op[7:6]         = 2'b11;
        Bus_Addr[3*AW +: AW] = AW'(16'h1234);
        Shared_In           = 4'b1000;
        @(posedge clk); #1;
        check_eq("rstmid_grant", 32'(Grant), 32'b1000);
        check_eq("rstmid_inv", 32'(Invalidate), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rstmid_outs", 32'({Grant, BusRd, BusRdX, Invalidate, Address_Com, Shared, Done}), 32'd0);
        check_eq("rstmid_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
        push_exp(3, 2'b11, AW'(16'h1234), 4'b1000);
        @(posedge clk); #1;
        check_eq("rstmid_regrant", 32'(Grant), 32'b1000);
        wait_done(1);
        Bus_Req = '0;
        Bus_Op  = '0;

        // contention
        contend(4'b1111, 5);
        contend(4'b1010, 4);

        repeat (5) @(negedge clk);
        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
